// File: rtl/processador_onchip_mem_arbiter.sv
// processador_onchip_mem_arbiter
//   Shares one single-port on-chip RAM (registered address, unregistered q)
//   between two Avalon-MM masters. Each access runs IDLE -> ACCESS (-> RDATA
//   for reads) -> IDLE, so writes complete in 2 clocks and reads in 3.
//   Ties are broken round-robin by default. Define ONCHIP_ARB_FIXED_PRIO_EN
//   to use fixed priority instead, where M0 always wins a tie.
module processador_onchip_mem_arbiter #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32,
    parameter int BE_W   = DATA_W / 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] m0_address,
    input  logic [BE_W-1:0]   m0_byteenable,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [DATA_W-1:0] m0_writedata,
    output logic [DATA_W-1:0] m0_readdata,
    output logic              m0_waitrequest,
    input  logic [ADDR_W-1:0] m1_address,
    input  logic [BE_W-1:0]   m1_byteenable,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [DATA_W-1:0] m1_writedata,
    output logic [DATA_W-1:0] m1_readdata,
    output logic              m1_waitrequest,
    output logic [ADDR_W-1:0] mem_address,
    output logic [BE_W-1:0]   mem_byteenable,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_writedata,
    output logic              mem_clken,
    input  logic [DATA_W-1:0] mem_readdata
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_RDATA  = 2'd2;

    logic [1:0]        state;
    logic              grant;
    logic              winner;
    logic              req0;
    logic              req1;
    logic [ADDR_W-1:0] sel_address;
    logic [BE_W-1:0]   sel_byteenable;
    logic              sel_write;
    logic [DATA_W-1:0] sel_writedata;

    assign req0      = m0_read | m0_write;
    assign req1      = m1_read | m1_write;
    assign mem_clken = 1'b1;

    // Mux of the granted master's command; write takes precedence over read
    always_comb begin
        sel_address    = grant ? m1_address    : m0_address;
        sel_byteenable = grant ? m1_byteenable : m0_byteenable;
        sel_write      = grant ? m1_write      : m0_write;
        sel_writedata  = grant ? m1_writedata  : m0_writedata;
    end

`ifdef ONCHIP_ARB_FIXED_PRIO_EN
    // Fixed priority: M1 only wins when M0 is not requesting
    always_comb begin
        winner = ~req0;
    end
`else
    logic last_grant;

    // Round-robin: a sole requester wins, a tie goes to the master not served last
    always_comb begin
        if (req0 && req1) begin
            winner = ~last_grant;
        end else begin
            winner = ~req0;
        end
    end

    // Remember who was granted most recently; reset favours M0 for the first tie
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_grant <= 1'b1;
        end else if (state == ST_IDLE && (req0 || req1)) begin
            last_grant <= winner;
        end
    end
`endif

    // Access sequencer: latch the winner in IDLE, walk ACCESS/RDATA, return to IDLE
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
            grant <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req0 || req1) begin
                        grant <= winner;
                        state <= ST_ACCESS;
                    end
                end
                ST_ACCESS: state <= sel_write ? ST_IDLE : ST_RDATA;
                ST_RDATA:  state <= ST_IDLE;
                default:   state <= ST_IDLE;
            endcase
        end
    end

    // RAM port and master responses; idle values keep everything quiet and stalled
    always_comb begin
        mem_address    = '0;
        mem_byteenable = '0;
        mem_chipselect = 1'b0;
        mem_write      = 1'b0;
        mem_writedata  = '0;
        m0_readdata    = '0;
        m1_readdata    = '0;
        m0_waitrequest = 1'b1;
        m1_waitrequest = 1'b1;
        case (state)
            ST_ACCESS: begin
                mem_chipselect = 1'b1;
                mem_address    = sel_address;
                mem_byteenable = sel_byteenable;
                mem_write      = sel_write;
                mem_writedata  = sel_writedata;
                if (sel_write) begin
                    if (grant) m1_waitrequest = 1'b0;
                    else       m0_waitrequest = 1'b0;
                end
            end
            ST_RDATA: begin
                if (grant) begin
                    m1_readdata    = mem_readdata;
                    m1_waitrequest = 1'b0;
                end else begin
                    m0_readdata    = mem_readdata;
                    m0_waitrequest = 1'b0;
                end
            end
            default: begin
            end
        endcase
    end

endmodule
